traffic_light_monitor: RTL and testbench

//  Passive checker on the light outputs of the four-approach traffic light controller.

---
 rtl/traffic_light_monitor.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Passive safety checker for the four-approach traffic light controller.
// Each approach (M1, M2, MT, S) has a tracker that follows its RED/GRN/YEL
// cycle. The monitor flags conflicting greens, illegal light codes, bad
// colour sequencing, wrong dwell times and red starvation. All error flags
// are sticky until clr_err. Lights are registered first, and every check
// then works on that registered sample, so a flag appears two edges after
// the offending light value is presented.
module traffic_light_monitor #(
    parameter int YEL_CYC     = 2,   // exact yellow length in cycles
    parameter int MIN_GRN_CYC = 3,   // shortest legal green in cycles
    parameter int MAX_RED_CYC = 30,  // red cycles tolerated before starvation
    parameter int CNT_W       = 8    // dwell counter / green counter width
) (
    input  logic             clk,
    input  logic             rst,          // asynchronous, active-low
    input  logic [2:0]       light_M1,
    input  logic [2:0]       light_M2,
    input  logic [2:0]       light_MT,
    input  logic [2:0]       light_S,
    input  logic             clr_err,
    output logic             err_conflict,
    output logic             err_illegal,
    output logic             err_sequence,
    output logic             err_timing,
    output logic             err_starve,
    output logic             err_any,
    output logic [3:0]       err_dir,      // {S, MT, M2, M1}
    output logic [CNT_W-1:0] s_green_cnt
);

    // Approach indices used throughout; err_dir follows the same order.
    localparam int IDX_M1 = 0;
    localparam int IDX_M2 = 1;
    localparam int IDX_MT = 2;
    localparam int IDX_S  = 3;

    // One-hot light encodings.
    localparam logic [2:0] CODE_RED = 3'b100;
    localparam logic [2:0] CODE_YEL = 3'b010;
    localparam logic [2:0] CODE_GRN = 3'b001;

    // Dwell thresholds expressed at counter width.
    localparam logic [CNT_W-1:0] DWELL_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DWELL_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] YEL_LEN   = CNT_W'(YEL_CYC);
    localparam logic [CNT_W-1:0] GRN_MIN   = CNT_W'(MIN_GRN_CYC);
    localparam logic [CNT_W-1:0] RED_LIMIT = CNT_W'(MAX_RED_CYC);

    typedef enum logic [1:0] {
        ST_UNK = 2'd0,
        ST_RED = 2'd1,
        ST_GRN = 2'd2,
        ST_YEL = 2'd3
    } trk_state_e;

    // Map a light code to the tracker colour; anything not one-hot is UNK.
    function automatic trk_state_e code_to_state(input logic [2:0] code);
        trk_state_e st;
        case (code)
            CODE_RED: st = ST_RED;
            CODE_GRN: st = ST_GRN;
            CODE_YEL: st = ST_YEL;
            default:  st = ST_UNK;
        endcase
        return st;
    endfunction

    // The only colour each colour may legally move to.
    function automatic trk_state_e legal_next(input trk_state_e cur);
        trk_state_e nxt;
        case (cur)
            ST_RED:  nxt = ST_GRN;
            ST_GRN:  nxt = ST_YEL;
            ST_YEL:  nxt = ST_RED;
            default: nxt = ST_UNK;
        endcase
        return nxt;
    endfunction

    // ------------------------------------------------------------------
    // Sample stage
    // ------------------------------------------------------------------
    logic [2:0] light_d [4];
    logic [2:0] light_q [4];
    logic       sample_vld_d;
    logic       sample_vld_q;  // low until the first post-reset sample exists

    // Gather the four light inputs into the sample array.
    always_comb begin
        light_d[IDX_M1] = light_M1;
        light_d[IDX_M2] = light_M2;
        light_d[IDX_MT] = light_MT;
        light_d[IDX_S]  = light_S;
        sample_vld_d    = 1'b1;
    end

    // Register the lights every cycle; the reset value 3'b000 is never checked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                light_q[i] <= 3'b000;
            end
            sample_vld_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                light_q[i] <= light_d[i];
            end
            sample_vld_q <= sample_vld_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-approach trackers
    // ------------------------------------------------------------------
    logic [3:0] code_legal;
    logic [3:0] ill_hit;
    logic [3:0] seq_hit;
    logic [3:0] tim_hit;
    logic [3:0] stv_hit;
    logic       s_grn_done;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_trk
            trk_state_e       state_q;
            trk_state_e       state_d;
            trk_state_e       smp_state;
            logic [CNT_W-1:0] dwell_q;
            logic [CNT_W-1:0] dwell_d;
            logic             ill_d;
            logic             seq_d;
            logic             tim_d;
            logic             stv_d;

            assign smp_state      = code_to_state(light_q[gi]);
            assign code_legal[gi] = (smp_state != ST_UNK);

            // Follow the colour cycle and judge each change of colour.
            always_comb begin
                state_d = state_q;
                dwell_d = dwell_q;
                ill_d   = 1'b0;
                seq_d   = 1'b0;
                tim_d   = 1'b0;
                stv_d   = 1'b0;
                if (sample_vld_q) begin
                    if (smp_state == ST_UNK) begin
                        // Illegal code: forget history and resynchronise.
                        ill_d   = 1'b1;
                        state_d = ST_UNK;
                        dwell_d = '0;
                    end else if (state_q == ST_UNK) begin
                        // First legal colour after reset or an illegal code.
                        state_d = smp_state;
                        dwell_d = DWELL_ONE;
                    end else if (smp_state == state_q) begin
                        if (dwell_q != DWELL_SAT) begin
                            dwell_d = dwell_q + DWELL_ONE;
                        end
                        // Fires exactly once per red interval: the count
                        // passes through MAX_RED_CYC+1 only once.
                        if (state_q == ST_RED && dwell_q == RED_LIMIT
                            && dwell_q != DWELL_SAT) begin
                            stv_d = 1'b1;
                        end
                    end else begin
                        // Colour change: dwell checks on the colour being
                        // left, then sequence check on the new colour.
                        if (state_q == ST_YEL && dwell_q != YEL_LEN) begin
                            tim_d = 1'b1;
                        end
                        if (state_q == ST_GRN && dwell_q < GRN_MIN) begin
                            tim_d = 1'b1;
                        end
                        if (smp_state != legal_next(state_q)) begin
                            seq_d = 1'b1;
                        end
                        state_d = smp_state;
                        dwell_d = DWELL_ONE;
                    end
                end
            end

            // Tracker state and dwell counter.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q <= ST_UNK;
                    dwell_q <= '0;
                end else begin
                    state_q <= state_d;
                    dwell_q <= dwell_d;
                end
            end

            assign ill_hit[gi] = ill_d;
            assign seq_hit[gi] = seq_d;
            assign tim_hit[gi] = tim_d;
            assign stv_hit[gi] = stv_d;

            // Only the side road counts completed greens.
            if (gi == IDX_S) begin : g_s_done
                assign s_grn_done = sample_vld_q && (state_q == ST_GRN)
                                    && (smp_state == ST_YEL);
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Conflict check on the registered samples
    // ------------------------------------------------------------------
    logic [3:0] active;
    logic       conf_hit;

    // An approach is active whenever it is not showing red; cycles with an
    // illegal code are reported only as illegal.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            active[i] = (light_q[i] != CODE_RED);
        end
        conf_hit = sample_vld_q && (&code_legal)
                   && ((active[IDX_S] && (active[IDX_M1] || active[IDX_M2]
                                          || active[IDX_MT]))
                       || (active[IDX_MT] && active[IDX_M2]));
    end

    // ------------------------------------------------------------------
    // Sticky flags, direction bitmap and side-road green counter
    // ------------------------------------------------------------------
    logic             conflict_q, conflict_d;
    logic             illegal_q,  illegal_d;
    logic             sequence_q, sequence_d;
    logic             timing_q,   timing_d;
    logic             starve_q,   starve_d;
    logic [3:0]       dir_q,      dir_d;
    logic [CNT_W-1:0] sgc_q,      sgc_d;

    // clr_err wipes the old flags, but an error found in the same cycle
    // still lands, so nothing is lost to a badly timed clear.
    always_comb begin
        conflict_d = (clr_err ? 1'b0 : conflict_q) | conf_hit;
        illegal_d  = (clr_err ? 1'b0 : illegal_q)  | (|ill_hit);
        sequence_d = (clr_err ? 1'b0 : sequence_q) | (|seq_hit);
        timing_d   = (clr_err ? 1'b0 : timing_q)   | (|tim_hit);
        starve_d   = (clr_err ? 1'b0 : starve_q)   | (|stv_hit);
        dir_d      = (clr_err ? 4'b0000 : dir_q)
                     | ill_hit | seq_hit | tim_hit | stv_hit;
        sgc_d      = sgc_q;
        if (s_grn_done && sgc_q != DWELL_SAT) begin
            sgc_d = sgc_q + DWELL_ONE;
        end
    end

    // Flag and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_q <= 1'b0;
            illegal_q  <= 1'b0;
            sequence_q <= 1'b0;
            timing_q   <= 1'b0;
            starve_q   <= 1'b0;
            dir_q      <= 4'b0000;
            sgc_q      <= '0;
        end else begin
            conflict_q <= conflict_d;
            illegal_q  <= illegal_d;
            sequence_q <= sequence_d;
            timing_q   <= timing_d;
            starve_q   <= starve_d;
            dir_q      <= dir_d;
            sgc_q      <= sgc_d;
        end
    end

    assign err_conflict = conflict_q;
    assign err_illegal  = illegal_q;
    assign err_sequence = sequence_q;
    assign err_timing   = timing_q;
    assign err_starve   = starve_q;
    assign err_any      = conflict_q | illegal_q | sequence_q | timing_q | starve_q;
    assign err_dir      = dir_q;
    assign s_green_cnt  = sgc_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: phase table, directed corner sequences
// and a randomized run, all scored against a colour/run-length model.
module tb_traffic_light_monitor;

    localparam int YEL_CYC     = 2;
    localparam int MIN_GRN_CYC = 3;
    localparam int MAX_RED_CYC = 30;
    localparam int CNT_W       = 8;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       l_m1 = R, l_m2 = R, l_mt = R, l_s = R;
    logic             clr_err = 1'b0;
    logic             err_conflict, err_illegal, err_sequence, err_timing;
    logic             err_starve, err_any;
    logic [3:0]       err_dir;
    logic [CNT_W-1:0] s_green_cnt;

    traffic_light_monitor #(
        .YEL_CYC(YEL_CYC), .MIN_GRN_CYC(MIN_GRN_CYC),
        .MAX_RED_CYC(MAX_RED_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .light_M1(l_m1), .light_M2(l_m2), .light_MT(l_mt), .light_S(l_s),
        .clr_err(clr_err),
        .err_conflict(err_conflict), .err_illegal(err_illegal),
        .err_sequence(err_sequence), .err_timing(err_timing),
        .err_starve(err_starve), .err_any(err_any),
        .err_dir(err_dir), .s_green_cnt(s_green_cnt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: colour 0=unknown 1=red 2=green 3=yellow, run length.
    int         col [4];
    int         run [4];
    logic [2:0] smp [4];
    bit         smp_vld;
    bit         m_conf, m_ill, m_seq, m_tim, m_stv;
    logic [3:0] m_dir;
    int         m_sgc;

    typedef struct {
        bit         rst_before;
        logic [2:0] m1, m2, mt, s;
        bit         clr;
        int         len;
        logic [4:0] ef;   // {conflict, illegal, sequence, timing, starve}
        logic [3:0] ed;
        int         es;
    } vec_t;

    vec_t       tbl [$];
    logic [2:0] cur [4];
    int         r;

    function automatic int decode(input logic [2:0] c);
        case (c)
            R: return 1;
            G: return 2;
            Y: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic [2:0] encode(input int c);
        case (c)
            2: return G;
            3: return Y;
            default: return R;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            col[i] = 0; run[i] = 0; smp[i] = 3'b000;
        end
        smp_vld = 0;
        {m_conf, m_ill, m_seq, m_tim, m_stv} = '0;
        m_dir = 4'b0000;
        m_sgc = 0;
    endtask

    // One clock edge of the model: judge the previous sample, then take a new one.
    task automatic model_edge();
        logic [2:0] now_l [4];
        bit n_conf, n_ill, n_seq, n_tim, n_stv, all_legal;
        bit act [4];
        logic [3:0] n_dir;
        int c;
        now_l[0] = l_m1; now_l[1] = l_m2; now_l[2] = l_mt; now_l[3] = l_s;
        {n_conf, n_ill, n_seq, n_tim, n_stv} = '0;
        n_dir = 4'b0000;
        all_legal = 1;
        if (smp_vld) begin
            for (int i = 0; i < 4; i++) begin
                c = decode(smp[i]);
                act[i] = (c != 1);
                if (c == 0) begin
                    n_ill = 1; n_dir[i] = 1'b1; col[i] = 0; run[i] = 0; all_legal = 0;
                end else if (col[i] == 0) begin
                    col[i] = c; run[i] = 1;
                end else if (c == col[i]) begin
                    run[i]++;
                    if (c == 1 && run[i] == MAX_RED_CYC + 1) begin
                        n_stv = 1; n_dir[i] = 1'b1;
                    end
                end else begin
                    if (col[i] == 3 && run[i] != YEL_CYC)    begin n_tim = 1; n_dir[i] = 1'b1; end
                    if (col[i] == 2 && run[i] < MIN_GRN_CYC) begin n_tim = 1; n_dir[i] = 1'b1; end
                    if (c != (col[i] % 3) + 1)               begin n_seq = 1; n_dir[i] = 1'b1; end
                    if (i == 3 && col[i] == 2 && c == 3 && m_sgc < 255) m_sgc++;
                    col[i] = c; run[i] = 1;
                end
            end
            if (all_legal && ((act[3] && (act[0] || act[1] || act[2])) || (act[1] && act[2])))
                n_conf = 1;
        end
        if (clr_err) begin
            {m_conf, m_ill, m_seq, m_tim, m_stv} = '0;
            m_dir = 4'b0000;
        end
        m_conf |= n_conf; m_ill |= n_ill; m_seq |= n_seq; m_tim |= n_tim; m_stv |= n_stv;
        m_dir |= n_dir;
        for (int i = 0; i < 4; i++) smp[i] = now_l[i];
        smp_vld = 1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "/conflict"}, err_conflict, m_conf);
        chk({tag, "/illegal"},  err_illegal,  m_ill);
        chk({tag, "/sequence"}, err_sequence, m_seq);
        chk({tag, "/timing"},   err_timing,   m_tim);
        chk({tag, "/starve"},   err_starve,   m_stv);
        chk({tag, "/any"},      err_any,      int'(m_conf | m_ill | m_seq | m_tim | m_stv));
        chk({tag, "/dir"},      err_dir,      m_dir);
        chk({tag, "/sgc"},      s_green_cnt,  m_sgc);
    endtask

    task automatic drive(input logic [2:0] a, b, c, d);
        l_m1 = a; l_m2 = b; l_mt = c; l_s = d;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic hold(input logic [2:0] a, b, c, d, input int n);
        drive(a, b, c, d);
        repeat (n) step("hold");
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        clr_err = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_model("reset");
        drive(R, R, R, R);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic apply_vec(input vec_t v);
        if (v.rst_before) do_reset();
        drive(v.m1, v.m2, v.mt, v.s);
        clr_err = v.clr;
        repeat (v.len) step("tbl");
        clr_err = 1'b0;
        chk("tbl_flags", {err_conflict, err_illegal, err_sequence, err_timing, err_starve}, v.ef);
        chk("tbl_dir", err_dir, v.ed);
        chk("tbl_sgc", s_green_cnt, v.es);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Legal cycle repeated three times.
        for (int rr = 0; rr < 3; rr++) begin
            tbl.push_back('{1'b0, G, G, R, R, 1'b0, 7, 5'b00000, 4'b0000, rr});
            tbl.push_back('{1'b0, G, Y, R, R, 1'b0, 2, 5'b00000, 4'b0000, rr});
            tbl.push_back('{1'b0, G, R, G, R, 1'b0, 5, 5'b00000, 4'b0000, rr});
            tbl.push_back('{1'b0, Y, R, Y, R, 1'b0, 2, 5'b00000, 4'b0000, rr});
            tbl.push_back('{1'b0, R, R, R, G, 1'b0, 3, 5'b00000, 4'b0000, rr});
            tbl.push_back('{1'b0, R, R, R, Y, 1'b0, 2, 5'b00000, 4'b0000, rr + 1});
        end
        // Conflict: S and M1 green together for one cycle.
        tbl.push_back('{1'b1, R, R, R, R, 1'b0, 3, 5'b00000, 4'b0000, 0});
        tbl.push_back('{1'b0, G, R, R, G, 1'b0, 1, 5'b00000, 4'b0000, 0});
        tbl.push_back('{1'b0, R, R, R, R, 1'b0, 1, 5'b10000, 4'b0000, 0});
        // Sequence: M2 green straight to red, then clear.
        tbl.push_back('{1'b1, R, R, R, R, 1'b0, 3, 5'b00000, 4'b0000, 0});
        tbl.push_back('{1'b0, R, G, R, R, 1'b0, 4, 5'b00000, 4'b0000, 0});
        tbl.push_back('{1'b0, R, R, R, R, 1'b0, 1, 5'b00000, 4'b0000, 0});
        tbl.push_back('{1'b0, R, R, R, R, 1'b0, 1, 5'b00100, 4'b0010, 0});
        tbl.push_back('{1'b0, R, R, R, R, 1'b1, 1, 5'b00000, 4'b0000, 0});

        do_reset();
        foreach (tbl[i]) apply_vec(tbl[i]);

        // Timing: S yellow held 3, then MT green held only 2.
        do_reset();
        hold(R, R, R, R, 2);
        hold(R, R, R, G, 3);
        hold(R, R, R, Y, 3);
        hold(R, R, R, R, 2);
        chk("s_yellow_long_timing", err_timing, 1);
        chk("s_yellow_long_dir", err_dir, 4'b1000);
        chk("s_yellow_long_sgc", s_green_cnt, 1);
        hold(R, R, G, R, 2);
        hold(R, R, Y, R, 2);
        hold(R, R, R, R, 2);
        chk("mt_green_short_dir", err_dir, 4'b1100);

        // Starvation: flagged on the 31st red sample, only once per interval.
        do_reset();
        hold(R, R, R, R, 31);
        chk("starve_before_limit", err_starve, 0);
        step("starve");
        chk("starve_at_limit", err_starve, 1);
        chk("starve_dir_s", err_dir[3], 1);
        clr_err = 1'b1;
        step("clr");
        clr_err = 1'b0;
        hold(R, R, R, R, 5);
        chk("starve_once", err_starve, 0);
        // Illegal code on M1.
        hold(3'b011, R, R, R, 1);
        hold(R, R, R, R, 1);
        chk("illegal_flag", err_illegal, 1);
        chk("illegal_dir", err_dir, 4'b0001);
        chk("illegal_no_conflict", err_conflict, 0);

        // Reset during M1 yellow with a sticky flag set.
        do_reset();
        hold(R, R, R, R, 2);
        hold(R, G, R, R, 3);
        hold(G, R, R, R, 3);
        hold(Y, R, R, R, 1);
        chk("pre_reset_sequence", err_sequence, 1);
        do_reset();
        chk("post_reset_any", err_any, 0);
        for (int i = 0; i < 6; i++) hold(tbl[i].m1, tbl[i].m2, tbl[i].mt, tbl[i].s, tbl[i].len);
        chk("post_reset_legal_any", err_any, 0);
        chk("post_reset_legal_sgc", s_green_cnt, 1);

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 4; i++) cur[i] = R;
        for (int k = 0; k < 3000; k++) begin
            for (int a = 0; a < 4; a++) begin
                r = $urandom_range(0, 99);
                if (r >= 99)      cur[a] = 3'($urandom_range(0, 7));
                else if (r >= 97) cur[a] = encode($urandom_range(1, 3));
                else if (r >= 90) cur[a] = encode((decode(cur[a]) % 3) + 1);
            end
            clr_err = ($urandom_range(0, 24) == 0);
            drive(cur[0], cur[1], cur[2], cur[3]);
            step("rand");
        end
        clr_err = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
